derotate16_seq: RTL and testbench
=================================

# derotate16_seq

Sequential 16-bit inverse rotator: accepts a word that was rotated by `amt` positions in direction `lr` and restores the original by rotating the opposite way, one position per clock (or up to four with the step option). Its `a`/`amt`/`lr` convention matches the combinational 16-bit left/right rotator, so it sits on the receive side of any path that rotated data through that unit. A start/ready/done handshake frees the datapath from a wide combinational mux tree.

## Interface
- No parameters; width fixed at 16, amount fixed at 4 bits.
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only while `ready`=1
- a  input  16  rotated word, sampled on the accepting edge
- amt  input  4  rotation amount originally applied (0–15), sampled with `a`
- lr  input  1  direction originally applied: 1 = was rotated left (undo by rotating right), 0 = was rotated right (undo by rotating left)
- y  output  16  restored word, registered; valid from `done` until the next result
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse, result on `y`

## Operation
- Reset: IDLE, `y`=16'h0000, `ready`=1, `busy`=0, `done`=0, internal work register and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: on `start`=1, load work reg ← `a`, cnt ← `amt`, dir ← `lr`. If `amt`=0, go to DONE; else go to RUN.
- RUN: each cycle rotate work reg by step s in inverse direction, cnt ← cnt − s. When cnt − s = 0, go to DONE. Without the option s=1.
- Transition into DONE loads `y` with the final work value (for `amt`=0, `y` ← `a`).
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` while `busy` is ignored; `a`/`amt`/`lr` changing during RUN have no effect.
- `y` holds its value through IDLE and the next RUN; it changes only on entry to DONE or on reset.
- Rotation is modulo 16; all arithmetic on cnt is 4-bit, never underflows (s ≤ cnt enforced).
- Reset during RUN/DONE: abort, return to reset values on the next edge, no `done` pulse.

## Timing
- Start accepted at edge T (IDLE, `start`=1). RUN cycles N = `amt` (no option).
- `done` high during cycle T+1+N; `y` valid from that cycle. `amt`=0 → `done` at T+1.
- `ready` low from T+1 through the `done` cycle; back high the cycle after `done`; earliest next accept one cycle after `done` (throughput one op per N+2 cycles).
- All outputs registered or decoded from state register; no combinational input-to-output paths.

## Configuration
- `DEROT_STEP4_EN` defined: in RUN, s=4 when cnt ≥ 4, else s=1. N = (`amt`>>2) + (`amt`&3); worst case 6 RUN cycles (`amt`=15). Results identical to the 1-step build.
- Not defined: s=1 always, N = `amt`, worst case 15 RUN cycles; no 4-position mux in the datapath.

## Test plan
- Reset with `start` held high → `y`=0, `ready`=1, `busy`=0, `done`=0 throughout reset; no accept until reset released.
- `a`=16'h8001, `amt`=4, `lr`=1 at T → `y`=16'h1800, `done` at T+5 (T+2 with `DEROT_STEP4_EN`).
- `a`=16'h1234, `amt`=8, `lr`=0 → `y`=16'h3412, `done` at T+9 (T+3 with option).
- `a`=16'h0001, `amt`=15, `lr`=1 → `y`=16'h0002, `done` at T+16 (T+7 with option); second `start` at T+3 ignored, `y` unchanged until `done`.
- `a`=16'hBEEF, `amt`=0 → `done` at T+1, `y`=16'hBEEF; back-to-back `start` accepted at T+2.
- Start `amt`=10, assert `reset` at T+3 → no `done`, `y`=0, IDLE next edge; round-trip check over all 16 amounts × both `lr` against forward rotator output returns original `a`.

Source files
------------

// File: rtl/derotate16_seq.sv
// rtl/derotate16_seq.sv - sequential 16-bit inverse rotator with start/ready/done handshake
//
// Undoes a rotation of `amt` positions in direction `lr` one position per
// clock. With DEROT_STEP4_EN defined the datapath may also step by four
// positions per clock while the remaining count is at least four.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   start  in   1   request, accepted only while ready=1
//   a      in   16  rotated word, sampled on the accepting edge
//   amt    in   4   rotation amount originally applied
//   lr     in   1   1 = was rotated left (undo right), 0 = was rotated right (undo left)
//   y      out  16  restored word, registered, changes only on entry to DONE
//   ready  out  1   high in IDLE
//   busy   out  1   high in RUN and DONE
//   done   out  1   single-cycle result pulse

module derotate16_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [3:0]  amt,
   input  logic        lr,
   output logic [15:0] y,
   output logic        ready,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state;
   logic [15:0] work;
   logic [3:0]  cnt;
   logic        dir;

   logic [3:0]  step;
   logic [15:0] work_nxt;

   // dir=1 means the word was rotated left, so each step rotates right.
`ifdef DEROT_STEP4_EN
   always_comb begin
      step     = (cnt >= 4'd4) ? 4'd4 : 4'd1;
      work_nxt = work;
      if (step == 4'd4)
         work_nxt = dir ? {work[3:0], work[15:4]} : {work[11:0], work[15:12]};
      else
         work_nxt = dir ? {work[0], work[15:1]} : {work[14:0], work[15]};
   end
`else
   always_comb begin
      step     = 4'd1;
      work_nxt = dir ? {work[0], work[15:1]} : {work[14:0], work[15]};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         y     <= 16'h0000;
         work  <= 16'h0000;
         cnt   <= 4'd0;
         dir   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  work <= a;
                  cnt  <= amt;
                  dir  <= lr;
                  if (amt == 4'd0) begin
                     y     <= a;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               work <= work_nxt;
               cnt  <= cnt - step;
               // step never exceeds cnt, so equality marks the final step
               if (cnt == step) begin
                  y     <= work_nxt;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready = (state == ST_IDLE);
   assign busy  = (state == ST_RUN) || (state == ST_DONE);
   assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_derotate16_seq.sv
// tb/tb_derotate16_seq.sv - randomized self-checking bench for derotate16_seq

module tb_derotate16_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [3:0]  amt;
   logic        lr;
   logic [15:0] y;
   logic        ready;
   logic        busy;
   logic        done;

   int n_checks;
   int n_fail;

   derotate16_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .amt   (amt),
      .lr    (lr),
      .y     (y),
      .ready (ready),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Rotate a 16-bit word by n positions, left or right, modulo 16.
   function automatic logic [15:0] rot(input logic [15:0] w, input int n, input bit left);
      logic [31:0] d;
      d = {w, w};
      if (left)
         return 16'((d << n) >> 16);
      else
         return 16'(d >> n);
   endfunction

   function automatic int run_cycles(input int n);
`ifdef DEROT_STEP4_EN
      return (n / 4) + (n % 4);
`else
      return n;
`endif
   endfunction

   // One operation: starts in an IDLE cycle, returns at the negedge of the done cycle.
   // poke > 0 raises start with junk inputs during that cycle number after accept.
   task automatic do_op(input logic [15:0] ai, input logic [3:0] amti, input logic lri,
                        input int poke, output logic [15:0] yo);
      logic [15:0] exp_y;
      logic [15:0] y_before;
      int          exp_done;
      int          k;
      bit          seen;
      exp_y    = rot(ai, int'(amti), !lri);
      exp_done = run_cycles(int'(amti)) + 1;
      @(negedge clk);
      check("ready_idle", {31'd0, ready}, 32'd1);
      check("done_idle", {31'd0, done}, 32'd0);
      y_before = y;
      a     = ai;
      amt   = amti;
      lr    = lri;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      amt   = 4'($urandom);
      lr    = 1'($urandom);
      k     = 1;
      seen  = 0;
      while (k <= 40 && !seen) begin
         if (done) begin
            seen = 1;
            check("done_cycle", k, exp_done);
            check("y_result", {16'd0, y}, {16'd0, exp_y});
            check("busy_done", {31'd0, busy}, 32'd1);
            check("ready_done", {31'd0, ready}, 32'd0);
            start = 1'b0;
         end else begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("ready_run", {31'd0, ready}, 32'd0);
            check("y_hold", {16'd0, y}, {16'd0, y_before});
            if (k == poke) begin
               start = 1'b1;
               a     = 16'($urandom);
               amt   = 4'($urandom);
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            k++;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      yo = y;
   endtask

   logic [15:0] yo;
   logic [15:0] orig;
   logic [15:0] fwd;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      start = 1'b1;
      a     = 16'hFFFF;
      amt   = 4'd0;
      lr    = 1'b0;

      // Reset held with start high: nothing may be accepted.
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_y", {16'd0, y}, 32'd0);
         check("rst_ready", {31'd0, ready}, 32'd1);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_done", {31'd0, done}, 32'd0);
      end
      reset = 1'b0;
      start = 1'b0;

      // Directed cases.
      do_op(16'h8001, 4'd4, 1'b1, 0, yo);
      check("dir_8001", {16'd0, yo}, 32'h1800);
      do_op(16'h1234, 4'd8, 1'b0, 0, yo);
      check("dir_1234", {16'd0, yo}, 32'h3412);
      do_op(16'h0001, 4'd15, 1'b1, 3, yo);
      check("dir_0001", {16'd0, yo}, 32'h0002);
      do_op(16'hBEEF, 4'd0, 1'b0, 0, yo);
      check("dir_beef", {16'd0, yo}, 32'hBEEF);
      do_op(16'hA5C3, 4'd1, 1'b0, 0, yo);

      // Randomized operations.
      for (int i = 0; i < 12; i++) begin
         do_op(16'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 4)), yo);
      end

      // Round trip through the forward rotator for every amount and direction.
      for (int n = 0; n < 16; n++) begin
         for (int d = 0; d < 2; d++) begin
            orig = 16'($urandom);
            fwd  = rot(orig, n, d[0]);
            do_op(fwd, 4'(n), d[0], 0, yo);
            check("roundtrip", {16'd0, yo}, {16'd0, orig});
         end
      end

      // Make y nonzero, then abort an amt=10 run with reset.
      do_op(16'hBEEF, 4'd0, 1'b0, 0, yo);
      @(negedge clk);
      a     = 16'h1357;
      amt   = 4'd10;
      lr    = 1'b1;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("abort_nodone", {31'd0, done}, 32'd0);
         check("abort_busy", {31'd0, busy}, 32'd1);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_y", {16'd0, y}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_busy_clr", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("abort_stay_idle", {31'd0, done}, 32'd0);

      // Recovery after abort.
      do_op(16'hC001, 4'd6, 1'b0, 0, yo);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
